track_epl_correlator: RTL and testbench

Next-generation tracking correlator for one GPS channel. Takes 3-bit sign-magnitude baseband samples and wipes off the C/A code at three taps: early, prompt and late. Each tap accumulates over a programmable number of code epochs, then dumps its results through a valid/ready handshake to the loop filter.
- Contains the code-rate NCO that steps an external C/A generator, so Doppler-adjusted chipping rates are supported.

---
 rtl/track_epl_correlator.sv | 165 ++++++++++++++++
 tb/tb_track_epl_correlator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/track_epl_correlator.sv
// track_epl_correlator
// Early/prompt/late C/A code correlator for one GPS tracking channel.
// A code-rate NCO steps an external C/A generator. The early chip from that
// generator is delayed through a shift register to form the prompt and late
// taps. Each tap wipes the code off 3-bit sign-magnitude samples and
// accumulates over int_epochs code periods. Results are then handed to the
// loop filter over a valid/ready handshake.
//
// Ports:
//   clk, reset        sample clock, synchronous active-high reset
//   sample_valid      qualifies sample_in / ca_bit / epoch_in; datapath advances only then
//   sample_in[2:0]    [2]=sign (1=negative), [1:0]=magnitude
//   code_rate_inc     NCO phase increment per valid sample
//   ca_bit            early code chip (1 => +1, 0 => -1)
//   epoch_in          generator is at chip 0
//   int_epochs        epochs per integration (0 behaves as 1)
//   chip_adv          one-cycle pulse: advance the C/A generator one chip
//   dump_valid/ready  result handshake
//   early/prompt/late_out  dumped sums (signed)
//   overrun           sticky: an undelivered dump was overwritten
//
// Build option: define TRACK_ACC_SATURATE_EN for saturating accumulators
// (pinned at the rail until the next dump); default is modular wrap.
module track_epl_correlator #(
    parameter int unsigned ACC_WIDTH       = 16,
    parameter int unsigned PHASE_WIDTH     = 24,
    parameter int unsigned TAP_DELAY       = 8,
    parameter int unsigned EPOCH_CNT_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sample_valid,
    input  logic [2:0]                  sample_in,
    input  logic [PHASE_WIDTH-1:0]      code_rate_inc,
    input  logic                        ca_bit,
    input  logic                        epoch_in,
    input  logic [EPOCH_CNT_WIDTH-1:0]  int_epochs,
    output logic                        chip_adv,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic signed [ACC_WIDTH-1:0] early_out,
    output logic signed [ACC_WIDTH-1:0] prompt_out,
    output logic signed [ACC_WIDTH-1:0] late_out,
    output logic                        overrun
);

    logic [PHASE_WIDTH-1:0]      phase_q;
    logic [PHASE_WIDTH:0]        nco_sum;
    logic [2*TAP_DELAY-1:0]      tap_sr_q;
    logic [2:0]                  tap;
    logic signed [ACC_WIDTH-1:0] acc_q [3];
    logic signed [ACC_WIDTH-1:0] val   [3];
    logic signed [ACC_WIDTH-1:0] sum   [3];
    logic                        started_q;
    logic [EPOCH_CNT_WIDTH-1:0]  cnt_q, target_q, cnt_inc, target_now;
    logic                        epoch_hit, start, boundary;

`ifdef TRACK_ACC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic [ACC_WIDTH:0] wide [3];
    logic               pin_q [3];
    logic               sat   [3];
`endif

    // Code wipe-off of one tap: +/-mag, sign-extended to the accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] wipe(input logic [2:0] s, input logic t);
        logic signed [ACC_WIDTH-1:0] mag;
        mag = {{(ACC_WIDTH-2){1'b0}}, s[1:0]};
        return (s[2] ^ ~t) ? -mag : mag;
    endfunction

    assign nco_sum    = {1'b0, phase_q} + {1'b0, code_rate_inc};
    assign tap        = {tap_sr_q[2*TAP_DELAY-1], tap_sr_q[TAP_DELAY-1], ca_bit};
    assign target_now = (int_epochs == '0) ? EPOCH_CNT_WIDTH'(1) : int_epochs;
    assign cnt_inc    = cnt_q + EPOCH_CNT_WIDTH'(1);
    assign epoch_hit  = sample_valid & epoch_in;
    // The first epoch after reset only aligns the integration window.
    assign start      = epoch_hit & ~started_q;
    assign boundary   = epoch_hit & started_q & (cnt_inc == target_q);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            val[i] = wipe(sample_in, tap[i]);
`ifdef TRACK_ACC_SATURATE_EN
            wide[i] = {acc_q[i][ACC_WIDTH-1], acc_q[i]} + {val[i][ACC_WIDTH-1], val[i]};
            if (pin_q[i]) begin
                sum[i] = acc_q[i];
                sat[i] = 1'b1;
            end else if (wide[i][ACC_WIDTH] != wide[i][ACC_WIDTH-1]) begin
                sum[i] = wide[i][ACC_WIDTH] ? AccMin : AccMax;
                sat[i] = 1'b1;
            end else begin
                sum[i] = wide[i][ACC_WIDTH-1:0];
                sat[i] = 1'b0;
            end
`else
            sum[i] = acc_q[i] + val[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= '0;
            tap_sr_q   <= '0;
            started_q  <= 1'b0;
            cnt_q      <= '0;
            target_q   <= EPOCH_CNT_WIDTH'(1);
            chip_adv   <= 1'b0;
            dump_valid <= 1'b0;
            early_out  <= '0;
            prompt_out <= '0;
            late_out   <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                acc_q[i] <= '0;
`ifdef TRACK_ACC_SATURATE_EN
                pin_q[i] <= 1'b0;
`endif
            end
        end else begin
            chip_adv <= 1'b0;
            if (sample_valid) begin
                phase_q  <= nco_sum[PHASE_WIDTH-1:0];
                chip_adv <= nco_sum[PHASE_WIDTH];
                tap_sr_q <= {tap_sr_q[2*TAP_DELAY-2:0], ca_bit};
            end

            // Boundary (and start) sample opens the new period with its own value.
            if (sample_valid && (started_q || start)) begin
                for (int i = 0; i < 3; i++) begin
                    acc_q[i] <= (start || boundary) ? val[i] : sum[i];
`ifdef TRACK_ACC_SATURATE_EN
                    pin_q[i] <= (start || boundary) ? 1'b0 : sat[i];
`endif
                end
            end

            if (start) begin
                started_q <= 1'b1;
                cnt_q     <= '0;
                target_q  <= target_now;
            end else if (boundary) begin
                cnt_q    <= '0;
                target_q <= target_now;
            end else if (epoch_hit) begin
                cnt_q <= cnt_inc;
            end

            if (boundary) begin
                early_out  <= acc_q[0];
                prompt_out <= acc_q[1];
                late_out   <= acc_q[2];
                dump_valid <= 1'b1;
                if (dump_valid && !dump_ready) begin
                    overrun <= 1'b1;
                end
            end else if (dump_valid && dump_ready) begin
                dump_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_track_epl_correlator.sv
module tb_track_epl_correlator;

    localparam int AW = 16;
    localparam int PW = 24;
    localparam int TD = 8;
    localparam int EW = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sample_valid;
    logic [2:0]           sample_in;
    logic [PW-1:0]        code_rate_inc;
    logic                 ca_bit;
    logic                 epoch_in;
    logic [EW-1:0]        int_epochs;
    logic                 chip_adv;
    logic                 dump_valid;
    logic                 dump_ready;
    logic signed [AW-1:0] early_out, prompt_out, late_out;
    logic                 overrun;

    always #5 clk = ~clk;

    track_epl_correlator #(
        .ACC_WIDTH(AW), .PHASE_WIDTH(PW), .TAP_DELAY(TD), .EPOCH_CNT_WIDTH(EW)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .code_rate_inc(code_rate_inc), .ca_bit(ca_bit), .epoch_in(epoch_in),
        .int_epochs(int_epochs), .chip_adv(chip_adv), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .early_out(early_out), .prompt_out(prompt_out),
        .late_out(late_out), .overrun(overrun)
    );

    typedef struct packed {
        logic signed [AW-1:0] e;
        logic signed [AW-1:0] p;
        logic signed [AW-1:0] l;
    } dump_t;

    dump_t exp_q[$];
    dump_t mon_d;
    int    checks = 0;
    int    failures = 0;
    int    n_done = 0;
    int    adv_count = 0;
    int    first_adv = -1;
    int    accepts = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int e, input int p, input int l);
        dump_t t;
        t.e = AW'(e);
        t.p = AW'(p);
        t.l = AW'(l);
        exp_q.push_back(t);
    endtask

    task automatic cyc(input logic v, input logic [2:0] s, input logic ca, input logic ep);
        sample_valid = v;
        sample_in    = s;
        ca_bit       = ca;
        epoch_in     = ep;
        @(posedge clk);
        #1;
        if (v) n_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        epoch_in     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic prerun(input int n, input logic [2:0] s, input logic ca);
        for (int i = 0; i < n; i++) cyc(1'b1, s, ca, 1'b0);
    endtask

    // Monitor: counts NCO pulses and scores every accepted dump.
    always @(negedge clk) begin
        if (!reset) begin
            if (chip_adv) begin
                adv_count++;
                if (first_adv < 0) first_adv = n_done;
            end
            if (dump_valid && dump_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_dump: got e=%0d p=%0d l=%0d, expected none",
                             early_out, prompt_out, late_out);
                end else begin
                    mon_d = exp_q.pop_front();
                    chk("dump_early", early_out, $signed(mon_d.e));
                    chk("dump_prompt", prompt_out, $signed(mon_d.p));
                    chk("dump_late", late_out, $signed(mon_d.l));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc0;
        bit  nz;
        reset = 1'b1; sample_valid = 1'b0; sample_in = '0; code_rate_inc = '0;
        ca_bit = 1'b0; epoch_in = 1'b0; int_epochs = EW'(1); dump_ready = 1'b0;
        do_reset();

        // Reset state and NCO pacing
        chk("rst_chip_adv", chip_adv, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_early", early_out, 0);
        chk("rst_prompt", prompt_out, 0);
        chk("rst_late", late_out, 0);
        chk("rst_overrun", overrun, 0);
        code_rate_inc = PW'(1021613);
        dump_ready = 1'b1;
        n_done = 0; adv_count = 0; first_adv = -1; nz = 0;
        for (int k = 0; k < 168; k++) begin
            cyc(1'b1, 3'b011, k[0], 1'b0);
            if (dump_valid || early_out != 0 || prompt_out != 0 || late_out != 0) nz = 1;
        end
        idle(3);
        chk("nco_first_pulse_after_sample", first_adv, 17);
        chk("nco_pulse_count_10_or_11", (adv_count == 10 || adv_count == 11), 1);
        chk("outputs_zero_before_first_epoch", nz, 0);

        // Constant +3, ca=1, one epoch per integration
        do_reset();
        int_epochs = EW'(1);
        dump_ready = 1'b1;
        prerun(20, 3'b011, 1'b1);
        acc0 = accepts;
        push_exp(3000, 3000, 3000);
        push_exp(3000, 3000, 3000);
        for (int k = 0; k <= 2000; k++) cyc(1'b1, 3'b011, 1'b1, (k % 1000) == 0);
        idle(3);
        chk("one_dump_per_epoch", accepts - acc0, 2);
        chk("no_overrun_when_ready", overrun, 0);

        // Tap spacing: short ca=1 burst just before a boundary; int_epochs=0 acts as 1
        do_reset();
        int_epochs = EW'(0);
        prerun(20, 3'b011, 1'b0);
        push_exp(-2952, -2976, -3000);
        push_exp(-3000, -2976, -2952);
        for (int k = 0; k <= 2000; k++)
            cyc(1'b1, 3'b011, (k >= 988 && k < 996), (k % 1000) == 0);
        idle(3);

        // Boundary in the same cycle as acceptance
        do_reset();
        int_epochs = EW'(1);
        dump_ready = 1'b0;
        prerun(20, 3'b001, 1'b1);
        push_exp(20, 20, 20);
        push_exp(40, 40, 40);
        for (int k = 0; k <= 40; k++) begin
            dump_ready = (k == 40);
            cyc(1'b1, (k < 20) ? 3'b001 : (k < 40) ? 3'b010 : 3'b011, 1'b1, (k % 20) == 0);
        end
        dump_ready = 1'b0;
        chk("same_cycle_accept_dv_held", dump_valid, 1);
        chk("same_cycle_accept_no_overrun", overrun, 0);
        chk("same_cycle_accept_new_early", early_out, 40);
        dump_ready = 1'b1;
        idle(1);
        dump_ready = 1'b0;
        chk("dv_clears_after_accept", dump_valid, 0);

        // Two boundaries without ready: newer data wins, overrun sticky
        do_reset();
        dump_ready = 1'b0;
        prerun(20, 3'b001, 1'b1);
        push_exp(40, 40, 40);
        for (int k = 0; k <= 40; k++)
            cyc(1'b1, (k < 20) ? 3'b001 : (k < 40) ? 3'b010 : 3'b011, 1'b1, (k % 20) == 0);
        chk("overrun_set", overrun, 1);
        chk("overrun_dv_held", dump_valid, 1);
        dump_ready = 1'b1;
        idle(1);
        dump_ready = 1'b0;
        idle(3);
        chk("overrun_sticky", overrun, 1);

        // Constant -3 over 12000 samples: wrap or saturate
        do_reset();
        dump_ready = 1'b1;
        prerun(20, 3'b111, 1'b1);
`ifdef TRACK_ACC_SATURATE_EN
        push_exp(-32768, -32768, -32768);
`else
        push_exp(29536, 29536, 29536);
`endif
        for (int k = 0; k <= 12000; k++) cyc(1'b1, 3'b111, 1'b1, (k % 12000) == 0);
        idle(3);

        // Reset mid-handshake with overrun pending
        do_reset();
        dump_ready = 1'b0;
        prerun(20, 3'b001, 1'b1);
        for (int k = 0; k <= 45; k++) cyc(1'b1, 3'b001, 1'b1, (k % 20) == 0);
        chk("pre_reset_dv", dump_valid, 1);
        chk("pre_reset_overrun", overrun, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_dump_valid", dump_valid, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_early", early_out, 0);
        chk("midrst_prompt", prompt_out, 0);
        chk("midrst_late", late_out, 0);
        reset = 1'b0;

        // sample_valid gaps carry junk (ca=0, -3, epoch) that must be ignored
        dump_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 3'b010, 1'b1, 1'b0);
            cyc(1'b0, 3'b111, 1'b0, 1'b1);
        end
        push_exp(40, 40, 40);
        for (int k = 0; k <= 20; k++) begin
            cyc(1'b1, 3'b010, 1'b1, (k % 20) == 0);
            cyc(1'b0, 3'b111, 1'b0, 1'b1);
        end
        idle(3);

        chk("all_expected_dumps_seen", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
